player_control: RTL
===================

# player_control

Frame-driven controller at the command end of the player ship datapath. Once per frame tick it sweeps the 2x4 sprite pixel offsets (`add_x`/`add_y`) to erase the ship in background colour. It then issues at most one single-cycle vertical move strobe (`y_pos_mod` up / `y_neg_mod` down) with the playfield limits enforced, and sweeps again to redraw in ship colour. The position datapath turns the offsets into VGA coordinates; `plot`/`colour` from this block go to the VGA adapter alongside them.

## Interface
Parameters:
- `Y_MIN`, 0: topmost legal base row.
- `Y_MAX`, 116: bottommost legal base row (120-line screen minus 4-row ship).
- `SHIP_COLOUR`, 3'b111: colour used during the draw pass.
- `BG_COLOUR`, 3'b000: colour used during the erase pass.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse, once per frame.
- `key_up` in 1: level, request upward move.
- `key_down` in 1: level, request downward move.
- `y_cur` in 7: current base row from the position datapath, unsigned.
- `add_x` out 1: sprite column offset.
- `add_y` out 2: sprite row offset.
- `y_pos_mod` out 1: one-cycle strobe, move ship up (row − 1).
- `y_neg_mod` out 1: one-cycle strobe, move ship down (row + 1).
- `plot` out 1: pixel write enable to VGA.
- `colour` out 3: pixel colour to VGA.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ERASE, MOVE, DRAW.
- IDLE: all outputs 0, `colour` = BG_COLOUR. On `frame_tick`, latch the direction and go to ERASE.
  - Direction is up if only `key_up` is high, down if only `key_down` is high, none otherwise.
- ERASE: 8 cycles, `plot`=1, `colour`=BG_COLOUR.
  - Offsets sweep row-major: `add_y` is the outer loop 0..3, `add_x` the inner loop 0..1.
  - Order is (0,0),(1,0),(0,1),…,(1,3).
  - After (1,3), go to MOVE.
- MOVE: 1 cycle, `plot`=0, `add_x`=0, `add_y`=0, so `y_cur` is the true base row.
  - `y_pos_mod`=1 iff the direction is up and `y_cur` > Y_MIN.
  - `y_neg_mod`=1 iff the direction is down and `y_cur` < Y_MAX.
  - Never both. At a limit, no strobe is issued.
  - Next state is DRAW.
- DRAW: identical sweep to ERASE with `colour`=SHIP_COLOUR. After (1,3), go to IDLE.
- A `frame_tick` arriving while `busy`=1 is dropped, not queued.
- Key changes after the latch have no effect until the next tick.
- Reset in any state: IDLE next edge, offsets 0, strobes 0, `plot` 0, `colour` BG_COLOUR, direction cleared. Any partial sweep is abandoned.

## Timing
- Tick accepted at edge T. ERASE covers T+1..T+8, MOVE is T+9, DRAW covers T+10..T+17, IDLE from T+18.
  - `busy` is high for exactly 17 cycles.
- Outputs are registered and change only on `clk` edges.
- `y_cur` is sampled combinationally in MOVE. The datapath applies the strobe on the MOVE→DRAW edge, so DRAW already sees the new row.
- A tick at T+18 or later is accepted. A tick at T+17 is dropped.

## Configuration
- `PLAYER_CTRL_IDLE_SKIP_EN`:
  - Defined: a tick with direction none, or with the move blocked at a limit, goes straight back to IDLE with no passes (`busy` stays 0). The exception is the first tick after reset, which always runs a full DRAW so the ship appears; it skips ERASE and MOVE and goes IDLE→DRAW.
  - Undefined: every accepted tick runs the full 17-cycle ERASE/MOVE/DRAW sequence.

## Structure
- `player_pkg` holds:
  - the state enum;
  - `SHIP_W`=2 and `SHIP_H`=4;
  - sweep length 8;
  - the default colour constants.
- Sub-module `sprite_sweep`: a 3-bit offset counter with `start`/`done`, emitting `add_x`/`add_y` and `last`. It is instanced once and restarted for both ERASE and DRAW.

## Test plan
- Reset, then tick with no keys (macro undefined):
  - ERASE emits 8 plots with colour 000 over offsets (0,0)…(1,3);
  - MOVE has no strobe;
  - DRAW emits 8 plots with colour 111;
  - `busy` is high for 17 cycles.
- `key_up`=1 with `y_cur`=50 → `y_pos_mod` high for exactly one cycle at T+9, `y_neg_mod` stays 0.
- `key_down`=1 with `y_cur`=116 → no strobe. `key_up`=1 with `y_cur`=0 → no strobe. Both passes still run.
- Both keys high with `y_cur`=60 → no strobe. A second tick at T+5 is dropped, and a tick at T+18 starts a new ERASE at T+19.
- `reset` asserted at T+4 of ERASE → next cycle `plot`=0, offsets 0, `busy`=0. The next tick restarts at (0,0).
- With `PLAYER_CTRL_IDLE_SKIP_EN`:
  - the first tick after reset gives 8 DRAW plots only;
  - later ticks with no key leave `busy`=0 and `plot`=0;
  - a tick with `key_down` and `y_cur`=10 runs the full sequence with `y_neg_mod` pulsed.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and constants for the player ship command controller.
package player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERASE,
        ST_MOVE,
        ST_DRAW
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_e;

    localparam int SHIP_W    = 2;
    localparam int SHIP_H    = 4;
    localparam int SWEEP_LEN = SHIP_W * SHIP_H;

    localparam logic [2:0] DEF_SHIP_COLOUR = 3'b111;
    localparam logic [2:0] DEF_BG_COLOUR   = 3'b000;

    // Conflicting or absent keys both mean "stay put".
    function automatic dir_e key_dir(input logic up, input logic down);
        if (up && !down)
            return DIR_UP;
        else if (down && !up)
            return DIR_DOWN;
        else
            return DIR_NONE;
    endfunction

endpackage

// File: rtl/sprite_sweep.sv
// Row-major 2x4 sprite offset sweep: add_x inner loop, add_y outer loop.
module sprite_sweep
    import player_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       add_x,
    output logic [1:0] add_y,
    output logic       last,
    output logic       done
);

    logic [2:0] cnt_q, cnt_d;
    logic       active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (last) begin
                cnt_d    = '0;
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign add_x = cnt_q[0];
    assign add_y = cnt_q[2:1];
    assign last  = active_q && (cnt_q == 3'(SWEEP_LEN - 1));
    assign done  = !active_q;

endmodule

// File: rtl/player_control.sv
// Frame-tick driven erase / move / redraw sequencer for the player ship.
// Optional PLAYER_CTRL_IDLE_SKIP_EN: skip passes when no move will happen.
module player_control
    import player_pkg::*;
#(
    parameter logic [6:0] Y_MIN       = 7'd0,
    parameter logic [6:0] Y_MAX       = 7'd116,
    parameter logic [2:0] SHIP_COLOUR = DEF_SHIP_COLOUR,
    parameter logic [2:0] BG_COLOUR   = DEF_BG_COLOUR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [6:0] y_cur,
    output logic       add_x,
    output logic [1:0] add_y,
    output logic       y_pos_mod,
    output logic       y_neg_mod,
    output logic       plot,
    output logic [2:0] colour,
    output logic       busy
);

    state_e state_q, state_d;
    dir_e   dir_q, dir_d;
    logic   sweep_start, sweep_last, sweep_done, sweep_end;

    function automatic logic can_move(input dir_e d, input logic [6:0] y);
        return ((d == DIR_UP) && (y > Y_MIN)) || ((d == DIR_DOWN) && (y < Y_MAX));
    endfunction

    sprite_sweep u_sweep (
        .clk   (clk),
        .reset (reset),
        .start (sweep_start),
        .add_x (add_x),
        .add_y (add_y),
        .last  (sweep_last),
        .done  (sweep_done)
    );

    assign sweep_end = sweep_last && !sweep_done;

`ifdef PLAYER_CTRL_IDLE_SKIP_EN
    // Ship has not been drawn since reset; first tick must paint it.
    logic drawn_q, drawn_d;
`endif

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        sweep_start = 1'b0;
`ifdef PLAYER_CTRL_IDLE_SKIP_EN
        drawn_d     = drawn_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    dir_d = key_dir(key_up, key_down);
`ifdef PLAYER_CTRL_IDLE_SKIP_EN
                    if (!drawn_q) begin
                        state_d     = ST_DRAW;
                        sweep_start = 1'b1;
                        drawn_d     = 1'b1;
                    end else if (can_move(key_dir(key_up, key_down), y_cur)) begin
                        state_d     = ST_ERASE;
                        sweep_start = 1'b1;
                    end
`else
                    state_d     = ST_ERASE;
                    sweep_start = 1'b1;
`endif
                end
            end
            ST_ERASE: if (sweep_end) state_d = ST_MOVE;
            ST_MOVE: begin
                state_d     = ST_DRAW;
                sweep_start = 1'b1;
            end
            ST_DRAW: if (sweep_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_NONE;
`ifdef PLAYER_CTRL_IDLE_SKIP_EN
            drawn_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
`ifdef PLAYER_CTRL_IDLE_SKIP_EN
            drawn_q <= drawn_d;
`endif
        end
    end

    // Offsets are zero in MOVE, so y_cur is the true base row here.
    assign y_pos_mod = (state_q == ST_MOVE) && (dir_q == DIR_UP)   && can_move(dir_q, y_cur);
    assign y_neg_mod = (state_q == ST_MOVE) && (dir_q == DIR_DOWN) && can_move(dir_q, y_cur);
    assign plot      = (state_q == ST_ERASE) || (state_q == ST_DRAW);
    assign colour    = (state_q == ST_DRAW) ? SHIP_COLOUR : BG_COLOUR;
    assign busy      = (state_q != ST_IDLE);

endmodule
